// File: rtl/riscv_pkg.sv
// Shared types for the decode/execute boundary: ALU opcodes, register
// address width and the control bundle carried from ID into EX.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLL  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_OR   = 4'h8,
    ALU_AND  = 4'h9,
    ALU_PASS = 4'hA
  } alu_op_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src;
    logic    lui_src;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
  } id_ex_ctrl_t;

  // A bubble must not write registers or touch memory; the remaining
  // control bits are harmless and are left as they were.
  function automatic id_ex_ctrl_t kill_side_effects(input id_ex_ctrl_t c);
    id_ex_ctrl_t r;
    r           = c;
    r.mem_read  = 1'b0;
    r.mem_write = 1'b0;
    r.reg_write = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: a load sitting in EX whose destination is read by the
// instruction currently offered by ID. x0 never creates a dependency.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  id_valid_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  output logic                  load_use_o
);

  logic rd_nonzero;
  logic rs1_dep;
  logic rs2_dep;

  assign rd_nonzero = (ex_rd_i != '0);
  assign rs1_dep    = id_uses_rs1_i & (id_rs1_i == ex_rd_i);
  assign rs2_dep    = id_uses_rs2_i & (id_rs2_i == ex_rd_i);
  assign load_use_o = ex_valid_i & ex_mem_read_i & rd_nonzero & id_valid_i
                    & (rs1_dep | rs2_dep);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush, downstream stall, load-use bubble
// insertion and saturating bubble/stall performance counters.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [XLEN-1:0]       pc_in,
  input  logic [XLEN-1:0]       rs1_data_in,
  input  logic [XLEN-1:0]       rs2_data_in,
  input  logic [XLEN-1:0]       imm_in,
  input  logic [REG_ADDR_W-1:0] rs1_in,
  input  logic [REG_ADDR_W-1:0] rs2_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  uses_rs1_in,
  input  logic                  uses_rs2_in,
  input  logic [3:0]            alu_op_in,
  input  logic                  alu_src_in,
  input  logic                  lui_src_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic                  valid_out,
  output logic [XLEN-1:0]       pc_out,
  output logic [XLEN-1:0]       rs1_data_out,
  output logic [XLEN-1:0]       rs2_data_out,
  output logic [XLEN-1:0]       imm_out,
  output logic [REG_ADDR_W-1:0] rs1_out,
  output logic [REG_ADDR_W-1:0] rs2_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  uses_rs1_out,
  output logic                  uses_rs2_out,
  output logic [3:0]            alu_op_out,
  output logic                  alu_src_out,
  output logic                  lui_src_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  reg_write_out,
  output logic                  mem_to_reg_out,
  output logic                  load_use_hazard,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  uses_rs1;
    logic                  uses_rs2;
  } id_ex_data_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             valid_q, valid_d;
  id_ex_data_t      data_q, data_d, data_in;
  id_ex_ctrl_t      ctrl_q, ctrl_d, ctrl_in;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign data_in = '{
    pc:       pc_in,
    rs1_data: rs1_data_in,
    rs2_data: rs2_data_in,
    imm:      imm_in,
    rs1:      rs1_in,
    rs2:      rs2_in,
    rd:       rd_in,
    uses_rs1: uses_rs1_in,
    uses_rs2: uses_rs2_in
  };

  assign ctrl_in = '{
    alu_op:     alu_op_t'(alu_op_in),
    alu_src:    alu_src_in,
    lui_src:    lui_src_in,
    mem_read:   mem_read_in,
    mem_write:  mem_write_in,
    reg_write:  reg_write_in,
    mem_to_reg: mem_to_reg_in
  };

  hazard_detect u_hazard_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rd_i       (data_q.rd),
    .id_valid_i    (valid_in),
    .id_uses_rs1_i (uses_rs1_in),
    .id_uses_rs2_i (uses_rs2_in),
    .id_rs1_i      (rs1_in),
    .id_rs2_i      (rs2_in),
    .load_use_o    (load_use_hazard)
  );

  assign ready_out = ~ex_stall & ~load_use_hazard & ~flush;

  // Next-state selection: flush beats stall beats load-use bubble beats capture.
  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    ctrl_d       = ctrl_q;
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = kill_side_effects(ctrl_q);
    end else if (ex_stall) begin
      stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + CNT_ONE;
    end else if (load_use_hazard) begin
      valid_d      = 1'b0;
      ctrl_d       = kill_side_effects(ctrl_q);
      bubble_cnt_d = (&bubble_cnt_q) ? bubble_cnt_q : bubble_cnt_q + CNT_ONE;
    end else if (valid_in) begin
      valid_d = 1'b1;
      data_d  = data_in;
      ctrl_d  = ctrl_in;
    end else begin
      valid_d = 1'b0;
      ctrl_d  = kill_side_effects(ctrl_q);
    end
  end

  // Pipeline register and counters; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      ctrl_q       <= '0;
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      ctrl_q       <= ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign valid_out      = valid_q;
  assign pc_out         = data_q.pc;
  assign rs1_data_out   = data_q.rs1_data;
  assign rs2_data_out   = data_q.rs2_data;
  assign imm_out        = data_q.imm;
  assign rs1_out        = data_q.rs1;
  assign rs2_out        = data_q.rs2;
  assign rd_out         = data_q.rd;
  assign uses_rs1_out   = data_q.uses_rs1;
  assign uses_rs2_out   = data_q.uses_rs2;
  assign alu_op_out     = ctrl_q.alu_op;
  assign alu_src_out    = ctrl_q.alu_src;
  assign lui_src_out    = ctrl_q.lui_src;
  assign mem_read_out   = ctrl_q.mem_read;
  assign mem_write_out  = ctrl_q.mem_write;
  assign reg_write_out  = ctrl_q.reg_write;
  assign mem_to_reg_out = ctrl_q.mem_to_reg;
  assign bubble_cnt     = bubble_cnt_q;
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_id_ex_stage;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic             valid_in = 0;
  logic [XLEN-1:0]  pc_in = 0, rs1_data_in = 0, rs2_data_in = 0, imm_in = 0;
  logic [4:0]       rs1_in = 0, rs2_in = 0, rd_in = 0;
  logic             uses_rs1_in = 0, uses_rs2_in = 0;
  logic [3:0]       alu_op_in = 0;
  logic             alu_src_in = 0, lui_src_in = 0, mem_read_in = 0;
  logic             mem_write_in = 0, reg_write_in = 0, mem_to_reg_in = 0;
  logic             ex_stall = 0, flush = 0;

  logic             ready_out, valid_out, load_use_hazard;
  logic [XLEN-1:0]  pc_out, rs1_data_out, rs2_data_out, imm_out;
  logic [4:0]       rs1_out, rs2_out, rd_out;
  logic             uses_rs1_out, uses_rs2_out;
  logic [3:0]       alu_op_out;
  logic             alu_src_out, lui_src_out, mem_read_out, mem_write_out;
  logic             reg_write_out, mem_to_reg_out;
  logic [CNT_W-1:0] bubble_cnt, stall_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .pc_in(pc_in), .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .imm_in(imm_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
    .uses_rs1_in(uses_rs1_in), .uses_rs2_in(uses_rs2_in),
    .alu_op_in(alu_op_in), .alu_src_in(alu_src_in), .lui_src_in(lui_src_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .ex_stall(ex_stall), .flush(flush), .valid_out(valid_out),
    .pc_out(pc_out), .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out),
    .imm_out(imm_out), .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
    .uses_rs1_out(uses_rs1_out), .uses_rs2_out(uses_rs2_out),
    .alu_op_out(alu_op_out), .alu_src_out(alu_src_out),
    .lui_src_out(lui_src_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .reg_write_out(reg_write_out),
    .mem_to_reg_out(mem_to_reg_out), .load_use_hazard(load_use_hazard),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  // Model: the instruction currently held for EX, plus the two counters.
  typedef struct {
    bit          valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    bit          u1, u2;
    logic [3:0]  op;
    bit          asrc, lsrc, mr, mw, rw, m2r;
  } instr_t;

  instr_t m;
  int     m_bub   = 0;
  int     m_stall = 0;
  int     n_vec   = 0;
  int     n_err   = 0;
  bit     cmp_en  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hazard();
    return m.valid && m.mr && (m.rd != 0) && valid_in &&
           ((uses_rs1_in && rs1_in == m.rd) || (uses_rs2_in && rs2_in == m.rd));
  endfunction

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Model advances at each clock edge from the inputs of that cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m = '{default: 0};
      m_bub = 0;
      m_stall = 0;
    end else begin
      bit hz;
      hz = model_hazard();
      if (flush) begin
        m.valid = 0; m.mr = 0; m.mw = 0; m.rw = 0;
      end else if (ex_stall) begin
        m_stall = sat(m_stall);
      end else if (hz) begin
        m.valid = 0; m.mr = 0; m.mw = 0; m.rw = 0;
        m_bub = sat(m_bub);
      end else if (valid_in) begin
        m.valid = 1;
        m.pc = pc_in; m.rs1d = rs1_data_in; m.rs2d = rs2_data_in; m.imm = imm_in;
        m.rs1 = rs1_in; m.rs2 = rs2_in; m.rd = rd_in;
        m.u1 = uses_rs1_in; m.u2 = uses_rs2_in; m.op = alu_op_in;
        m.asrc = alu_src_in; m.lsrc = lui_src_in; m.mr = mem_read_in;
        m.mw = mem_write_in; m.rw = reg_write_in; m.m2r = mem_to_reg_in;
      end else begin
        m.valid = 0; m.mr = 0; m.mw = 0; m.rw = 0;
      end
    end
  end

  // Compare DUT against model mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid_out", valid_out, m.valid);
      chk("reg_write_out", reg_write_out, m.rw);
      chk("mem_read_out", mem_read_out, m.mr);
      chk("mem_write_out", mem_write_out, m.mw);
      chk("bubble_cnt", bubble_cnt, m_bub);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("load_use_hazard", load_use_hazard, model_hazard());
      chk("ready_out", ready_out, !ex_stall && !flush && !model_hazard());
      if (m.valid) begin
        chk("pc_out", pc_out, m.pc);
        chk("rs1_data_out", rs1_data_out, m.rs1d);
        chk("rs2_data_out", rs2_data_out, m.rs2d);
        chk("imm_out", imm_out, m.imm);
        chk("rs1_out", rs1_out, m.rs1);
        chk("rs2_out", rs2_out, m.rs2);
        chk("rd_out", rd_out, m.rd);
        chk("uses_rs1_out", uses_rs1_out, m.u1);
        chk("uses_rs2_out", uses_rs2_out, m.u2);
        chk("alu_op_out", alu_op_out, m.op);
        chk("alu_src_out", alu_src_out, m.asrc);
        chk("lui_src_out", lui_src_out, m.lsrc);
        chk("mem_to_reg_out", mem_to_reg_out, m.m2r);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in = 0; pc_in = 0; rs1_data_in = 0; rs2_data_in = 0; imm_in = 0;
    rs1_in = 0; rs2_in = 0; rd_in = 0; uses_rs1_in = 0; uses_rs2_in = 0;
    alu_op_in = 0; alu_src_in = 0; lui_src_in = 0; mem_read_in = 0;
    mem_write_in = 0; reg_write_in = 0; mem_to_reg_in = 0;
    ex_stall = 0; flush = 0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic u1, input logic u2,
                       input logic [3:0] op, input logic mr, input logic mw, input logic rw);
    valid_in = 1; pc_in = pc; rs1_in = rs1; rs2_in = rs2; rd_in = rd;
    uses_rs1_in = u1; uses_rs2_in = u2; alu_op_in = op;
    mem_read_in = mr; mem_write_in = mw; reg_write_in = rw; mem_to_reg_in = mr;
    rs1_data_in = $urandom; rs2_data_in = $urandom; imm_in = $urandom;
    alu_src_in = 1'($urandom); lui_src_in = 1'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 0;
    #4 rst_n = 1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    cmp_en = 1;
    chk("reset valid_out", valid_out, 0);
    chk("reset bubble_cnt", bubble_cnt, 0);
    chk("reset stall_cnt", stall_cnt, 0);

    // Normal capture, one-cycle latency.
    drive(32'h100, 5'd1, 5'd2, 5'd5, 1, 1, 4'h2, 0, 0, 1);
    tick();
    chk("norm valid_out", valid_out, 1);
    chk("norm pc_out", pc_out, 32'h100);
    chk("norm alu_op_out", alu_op_out, 4'h2);
    chk("norm rd_out", rd_out, 5);

    // Asynchronous reset mid-cycle, then capture on first edge after release.
    ex_stall = 1;
    tick();
    chk("pre-reset stall_cnt", stall_cnt, 1);
    #1 rst_n = 0;
    #1;
    chk("async valid_out", valid_out, 0);
    chk("async pc_out", pc_out, 0);
    chk("async rd_out", rd_out, 0);
    chk("async reg_write_out", reg_write_out, 0);
    chk("async stall_cnt", stall_cnt, 0);
    ex_stall = 0;
    drive(32'h300, 5'd0, 5'd0, 5'd3, 0, 0, 4'h0, 0, 0, 1);
    #3 rst_n = 1;
    tick();
    chk("post-reset valid_out", valid_out, 1);
    chk("post-reset pc_out", pc_out, 32'h300);

    // Load-use: lw x7 followed by consumer of x7.
    idle(); do_reset();
    drive(32'h400, 5'd0, 5'd0, 5'd7, 0, 0, 4'h0, 1, 0, 1);
    tick();
    drive(32'h404, 5'd7, 5'd3, 5'd8, 1, 1, 4'h0, 0, 0, 1);
    #1;
    chk("lu hazard", load_use_hazard, 1);
    chk("lu ready_out", ready_out, 0);
    tick();
    chk("lu bubble valid_out", valid_out, 0);
    chk("lu bubble_cnt", bubble_cnt, 1);
    chk("lu bubble reg_write", reg_write_out, 0);
    tick();
    chk("lu add valid_out", valid_out, 1);
    chk("lu add rd_out", rd_out, 8);
    chk("lu add pc_out", pc_out, 32'h404);

    // Load to x0 never creates a hazard.
    idle(); do_reset();
    drive(32'h500, 5'd0, 5'd0, 5'd0, 0, 0, 4'h0, 1, 0, 1);
    tick();
    drive(32'h504, 5'd0, 5'd0, 5'd9, 1, 0, 4'h0, 0, 0, 1);
    #1;
    chk("x0 hazard", load_use_hazard, 0);
    chk("x0 ready_out", ready_out, 1);
    tick();
    chk("x0 rd_out", rd_out, 9);
    chk("x0 bubble_cnt", bubble_cnt, 0);

    // Three-cycle stall holds outputs.
    idle(); do_reset();
    drive(32'h200, 5'd1, 5'd2, 5'd3, 1, 1, 4'h1, 0, 0, 1);
    tick();
    ex_stall = 1;
    drive(32'h204, 5'd1, 5'd2, 5'd4, 1, 1, 4'h1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall pc_out", pc_out, 32'h200);
      chk("stall valid_out", valid_out, 1);
    end
    chk("stall stall_cnt", stall_cnt, 3);

    // Flush on the second stall cycle wins.
    idle(); do_reset();
    drive(32'h200, 5'd1, 5'd2, 5'd3, 1, 1, 4'h1, 0, 0, 1);
    tick();
    ex_stall = 1;
    tick();
    chk("sf stall_cnt c1", stall_cnt, 1);
    flush = 1;
    tick();
    chk("sf valid_out", valid_out, 0);
    chk("sf reg_write_out", reg_write_out, 0);
    chk("sf stall_cnt", stall_cnt, 1);

    // Counter saturation at all-ones.
    idle(); do_reset();
    ex_stall = 1;
    repeat (17) tick();
    chk("sat stall_cnt", stall_cnt, 15);

    // Randomized traffic.
    idle();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        idle();
        do_reset();
      end
      valid_in      = ($urandom_range(0, 4) != 0);
      ex_stall      = ($urandom_range(0, 4) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      pc_in         = $urandom;
      rs1_data_in   = $urandom;
      rs2_data_in   = $urandom;
      imm_in        = $urandom;
      rs1_in        = 5'($urandom_range(0, 3));
      rs2_in        = 5'($urandom_range(0, 3));
      rd_in         = 5'($urandom_range(0, 3));
      uses_rs1_in   = 1'($urandom);
      uses_rs2_in   = 1'($urandom);
      alu_op_in     = 4'($urandom);
      alu_src_in    = 1'($urandom);
      lui_src_in    = 1'($urandom);
      mem_read_in   = 1'($urandom);
      mem_write_in  = 1'($urandom);
      reg_write_in  = 1'($urandom);
      mem_to_reg_in = 1'($urandom);
      tick();
    end

    idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter CNT_W, default 16, width of performance counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 valid_in  input  1  ID presents a decoded instruction.
REQ-006 ready_out  output  1  stage accepts ID instruction this cycle (combinational).
REQ-007 pc_in, rs1_data_in, rs2_data_in, imm_in  input  XLEN each  decoded operands.
REQ-008 rs1_in, rs2_in, rd_in  input  5 each  register addresses.
REQ-009 uses_rs1_in, uses_rs2_in  input  1 each  instruction reads rs1/rs2.
REQ-010 alu_op_in  input  4, alu_src_in, lui_src_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in  input  1 each  control.
REQ-011 ex_stall  input  1  EX/downstream cannot accept; hold contents.
REQ-012 flush  input  1  branch/exception squash.
REQ-013 valid_out plus registered copies of every REQ-007..REQ-010 field (suffix _out)  output  same widths  to EX.
REQ-014 load_use_hazard  output  1  combinational hazard indication to ID/PC logic.
REQ-015 bubble_cnt, stall_cnt  output  CNT_W each  performance counters.

Function
REQ-016 load_use_hazard SHALL be valid_out & mem_read_out & (rd_out != 0) & valid_in & ((uses_rs1_in & rs1_in == rd_out) | (uses_rs2_in & rs2_in == rd_out)).
REQ-017 ready_out SHALL equal ~ex_stall & ~load_use_hazard & ~flush.
REQ-018 Per cycle, priority: flush > ex_stall > load_use_hazard > normal capture.
REQ-019 flush: valid_out <= 0; reg_write_out, mem_read_out, mem_write_out <= 0; other fields don't-care; ID instruction not accepted.
REQ-020 ex_stall (no flush): all outputs hold their values.
REQ-021 hazard (no flush, no stall): insert one bubble -- valid_out <= 0, side-effect controls <= 0; ID instruction held.
REQ-022 Normal: if valid_in, capture all inputs, valid_out <= 1; else valid_out <= 0 with side-effect controls cleared.
REQ-023 Latency SHALL be exactly one cycle from accepted input to output.
REQ-024 A load-use hazard SHALL insert exactly one bubble (hazard self-clears because bubble has valid_out = 0).
REQ-025 When valid_out = 0, reg_write_out, mem_read_out, mem_write_out SHALL be 0.
REQ-026 bubble_cnt SHALL increment on each cycle REQ-021 applies; stall_cnt on each cycle ex_stall is high and flush low; both saturate at all-ones.
REQ-027 rd = x0 SHALL never cause a hazard.

Reset
REQ-028 rst_n low SHALL immediately clear valid_out, every _out field, bubble_cnt and stall_cnt to 0, independent of clk.
REQ-029 Reset deassertion mid-stream: first capture SHALL occur on first rising edge with rst_n high.

Structure
REQ-030 Package riscv_pkg SHALL hold alu_op_t (4-bit enum), XLEN default, REG_ADDR_W = 5, and the id_ex control bundle struct.
REQ-031 Load-use comparison SHALL be a sub-module hazard_detect (purely combinational), instantiated once.

Verification
REQ-032 Reset: rst_n low mid-cycle with valid_out = 1 -> all outputs 0 before next edge.
REQ-033 Normal flow: valid_in = 1, pc_in = 0x100, alu_op_in = 4'h2, rd_in = 5 -> next cycle valid_out = 1, pc_out = 0x100, alu_op_out = 4'h2, rd_out = 5.
REQ-034 Load-use: EX holds lw rd = 7; ID add uses rs1 = 7 -> load_use_hazard = 1, ready_out = 0, next cycle valid_out = 0, bubble_cnt = 1; following cycle add captured.
REQ-035 rd = 0 load followed by rs1 = 0 consumer -> no hazard, no bubble.
REQ-036 ex_stall held 3 cycles with valid_out = 1 -> outputs unchanged, stall_cnt = 3; simultaneous flush on cycle 2 -> valid_out = 0, reg_write_out = 0, stall_cnt stays 1.
REQ-037 stall_cnt preloaded near saturation (CNT_W = 4, 15 stall cycles then 2 more) -> stall_cnt = 15.
